// File: rtl/spi_pkg.sv
// Shared defaults and state type for the SPI receive slave.
package spi_pkg;

    localparam int unsigned DATA_W_DEFAULT     = 32;
    localparam int unsigned FIFO_DEPTH_DEFAULT = 4;

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

endpackage

// File: rtl/spi_rx_fifo.sv
// First-word-fall-through receive FIFO with extra pointer bit for full/empty.
module spi_rx_fifo
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    parameter int unsigned DEPTH  = FIFO_DEPTH_DEFAULT
) (
    input  logic              clk_sys_i,
    input  logic              rst_i,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_full
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW:0]       r_wptr;
    logic [AW:0]       r_rptr;
    logic              w_empty;
    logic              w_pop;
    logic              w_push;

    assign w_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop   = i_pop & ~w_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign w_push  = i_push & (~o_full | w_pop);
    assign o_valid = ~w_empty;
    assign o_data  = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk_sys_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wptr[AW-1:0]] <= i_data;
                r_wptr                <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 receive-only slave: synchronizers, frame FSM, shifter, and RX FIFO.
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEFAULT,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic              clk_sys_i,
    input  logic              rst_i,
    input  logic              spi_sclk_i,
    input  logic              spi_sdi_i,
    input  logic              spi_cs_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    input  logic              rd_ready_i,
    output logic              frame_done_o,
    output logic [7:0]        word_cnt_o,
    output logic              overflow_o,
    output logic              frame_err_o,
    input  logic              clr_i
);

    localparam int unsigned     BW       = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BW-1:0]   LAST_BIT = BW'(DATA_W - 1);

    logic r_sclk_meta, r_sclk_sync, r_sclk_d;
    logic r_sdi_meta,  r_sdi_sync,  r_sdi_d;
    logic r_cs_meta,   r_cs_sync,   r_cs_d;

    state_t            r_state;
    logic [DATA_W-1:0] r_shift;
    logic [BW-1:0]     r_bit_cnt;
    logic              r_push;
    logic [7:0]        r_word_cnt;
    logic              r_frame_done;
    logic              r_frame_err;
    logic              r_overflow;

    logic w_sclk_rise;
    logic w_cs_fall;
    logic w_cs_rise;
    logic w_fifo_full;

    always_ff @(posedge clk_sys_i or posedge rst_i) begin
        if (rst_i) begin
            {r_sclk_meta, r_sclk_sync, r_sclk_d} <= 3'b000;
            {r_sdi_meta,  r_sdi_sync,  r_sdi_d}  <= 3'b000;
            {r_cs_meta,   r_cs_sync,   r_cs_d}   <= 3'b111;
        end else begin
            {r_sclk_meta, r_sclk_sync, r_sclk_d} <= {spi_sclk_i, r_sclk_meta, r_sclk_sync};
            {r_sdi_meta,  r_sdi_sync,  r_sdi_d}  <= {spi_sdi_i,  r_sdi_meta,  r_sdi_sync};
            {r_cs_meta,   r_cs_sync,   r_cs_d}   <= {spi_cs_i,   r_cs_meta,   r_cs_sync};
        end
    end

    assign w_sclk_rise = r_sclk_sync & ~r_sclk_d;
    assign w_cs_fall   = ~r_cs_sync & r_cs_d;
    assign w_cs_rise   = r_cs_sync & ~r_cs_d;

    // Data is taken from the delayed stage, i.e. the level present just before the rising edge.
    always_ff @(posedge clk_sys_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= IDLE;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_push       <= 1'b0;
            r_word_cnt   <= '0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_push       <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_cs_fall) begin
                        r_state    <= ACTIVE;
                        r_bit_cnt  <= '0;
                        r_word_cnt <= '0;
                    end
                end
                ACTIVE: begin
                    if (w_cs_rise) begin
                        r_state      <= IDLE;
                        r_frame_done <= 1'b1;
                    end else if (w_sclk_rise) begin
                        r_shift <= {r_shift[DATA_W-2:0], r_sdi_d};
                        if (r_bit_cnt == LAST_BIT) begin
                            r_bit_cnt <= '0;
                            r_push    <= 1'b1;
                            if (r_word_cnt != 8'hFF) begin
                                r_word_cnt <= r_word_cnt + 1'b1;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
            endcase
            if (r_state == ACTIVE && w_cs_rise && r_bit_cnt != '0) begin
                r_frame_err <= 1'b1;
            end else if (clr_i) begin
                r_frame_err <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_sys_i or posedge rst_i) begin
        if (rst_i) begin
            r_overflow <= 1'b0;
        end else if (r_push && w_fifo_full && !(rd_valid_o && rd_ready_i)) begin
            r_overflow <= 1'b1;
        end else if (clr_i) begin
            r_overflow <= 1'b0;
        end
    end

    spi_rx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk_sys_i (clk_sys_i),
        .rst_i     (rst_i),
        .i_push    (r_push),
        .i_data    (r_shift),
        .i_pop     (rd_ready_i),
        .o_data    (rd_data_o),
        .o_valid   (rd_valid_o),
        .o_full    (w_fifo_full)
    );

    assign frame_done_o = r_frame_done;
    assign word_cnt_o   = r_word_cnt;
    assign overflow_o   = r_overflow;
    assign frame_err_o  = r_frame_err;

endmodule

// File: doc/spi_slave_rx.md
SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

Interface
REQ-001 SHALL have parameter DATA_W, default 32: bits per word, MSB first.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: receive FIFO entries, power of two.
REQ-003 SHALL have one clock and one reset: clk_sys_i is the sole clock; rst_i is asynchronous and active-high.
REQ-004 clk_sys_i  input  1  system clock; all state is in this domain.
REQ-005 rst_i  input  1  asynchronous active-high reset.
REQ-006 spi_sclk_i  input  1  SPI clock from the master, asynchronous to clk_sys_i.
REQ-007 spi_sdi_i  input  1  serial data from the master.
REQ-008 spi_cs_i  input  1  chip select, active-low.
REQ-009 rd_data_o  output  DATA_W  FIFO head word.
REQ-010 rd_valid_o  output  1  FIFO not empty.
REQ-011 rd_ready_i  input  1  consumer accepts the head; a pop occurs when rd_valid_o and rd_ready_i are both high.
REQ-012 frame_done_o  output  1  one-cycle pulse at the end of each frame.
REQ-013 word_cnt_o  output  8  complete words received in the current or last frame; saturates at 255.
REQ-014 overflow_o  output  1  sticky flag: a word was dropped because the FIFO was full.
REQ-015 frame_err_o  output  1  sticky flag: chip select deasserted with a partial word.
REQ-016 clr_i  input  1  clears both sticky flags.

Function
REQ-017 SHALL pass spi_sclk_i, spi_sdi_i and spi_cs_i through 2-flop synchronizers, then register each once more for edge detection.
REQ-018 SHALL support SPI mode 0 only: sample data on the synchronized sclk rising edge.
REQ-019 Each sclk high and low phase SHALL last at least 3 clk_sys_i cycles; faster sclk is out of scope.
REQ-020 SHALL implement the FSM IDLE -> ACTIVE on a synchronized cs falling edge, clearing the bit counter and word_cnt_o.
REQ-021 In ACTIVE, each sclk rising edge SHALL shift the sampled data bit into the LSB of the shift register and increment the bit counter.
REQ-022 On the DATA_W-th bit, the assembled word SHALL be pushed into the FIFO in the next cycle, the bit counter SHALL wrap to 0, and word_cnt_o SHALL increment.
REQ-023 ACTIVE -> IDLE SHALL occur on a synchronized cs rising edge.
REQ-024 On that transition frame_done_o SHALL pulse for one cycle.
REQ-025 If the bit counter is nonzero at that transition, the partial word SHALL be discarded and frame_err_o SHALL be set.
REQ-026 If an sclk rising edge and a cs rising edge are detected in the same cycle, the cs edge SHALL win and the bit SHALL be ignored.
REQ-027 sclk edges SHALL be ignored in IDLE.
REQ-028 A push into a full FIFO SHALL drop the word and set overflow_o, unless a pop occurs in the same cycle, in which case the push SHALL be accepted.
REQ-029 The FIFO SHALL be first-word-fall-through, so rd_valid_o rises the cycle after a push into an empty FIFO.
REQ-030 Read and write pointers SHALL wrap modulo FIFO_DEPTH, with one extra bit to distinguish full from empty.
REQ-031 A pop on an empty FIFO SHALL have no effect.
REQ-032 If clr_i and a flag-set event occur in the same cycle, the set SHALL win.

Reset
REQ-033 rst_i SHALL force the FSM to IDLE and clear the synchronizers (cs to 1, others to 0), the shift register, the bit counter and the FIFO pointers.
REQ-034 Reset values SHALL be: rd_data_o=0, rd_valid_o=0, frame_done_o=0, word_cnt_o=0, overflow_o=0, frame_err_o=0.
REQ-035 Reset asserted mid-frame SHALL discard all data; after release, the next word SHALL be accepted only after a fresh cs falling edge.

Structure
REQ-036 Package spi_pkg SHALL hold the DATA_W and FIFO_DEPTH defaults and the state enum {IDLE, ACTIVE}.
REQ-037 The FIFO SHALL be a separate sub-module, spi_rx_fifo; synchronizers, FSM and shift logic SHALL stay in spi_slave_rx.

Verification
REQ-038 One frame, word 0xA5A5_1234 at sclk=clk/8, rd_ready_i=1: rd_data_o=0xA5A51234 with one rd_valid_o beat, frame_done_o one pulse, word_cnt_o=1, no flags.
REQ-039 Three-word frame 0x1, 0x2, 0x3 with rd_ready_i=0: FIFO holds 3 words; after rd_ready_i=1, output is 1, 2, 3 in order, and rd_valid_o drops after the third pop.
REQ-040 Six-word frame with rd_ready_i=0 (depth 4): words 1-4 are retained, words 5-6 are dropped, overflow_o=1; clr_i clears it.
REQ-041 cs deasserted after 13 bits: frame_err_o=1, FIFO stays empty, word_cnt_o=0, frame_done_o pulses.
REQ-042 rst_i asserted after 20 bits of a frame, then a new 32-bit frame 0xDEADBEEF: only 0xDEADBEEF is received, and no flags are set.
REQ-043 FIFO full with pop and push in the same cycle: push accepted, FIFO stays full, overflow_o=0.
